// File: rtl/simple_pkg.sv
// Shared encodings for the SIMPLE 16-bit processor: sequencer phases,
// writeback classes, flag bit positions and datapath widths.
package simple_pkg;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 3;

   localparam logic [2:0] ST_DECODE = 3'b010;
   localparam logic [2:0] ST_EXEC   = 3'b100;
   localparam logic [2:0] ST_WB     = 3'b101;

   typedef enum logic [1:0] {
      WB_NONE = 2'b00,
      WB_ALU  = 2'b01,
      WB_LOAD = 2'b10,
      WB_RSVD = 2'b11
   } wb_class_t;

   // Bit positions within the {S,Z,C,V} flag nibble.
   localparam int FLAG_S = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef enum logic [1:0] {
      WB_IDLE     = 2'b00,
      WB_WAIT_MEM = 2'b01,
      WB_ARMED    = 2'b10
   } wb_fsm_t;

   // The reserved class retires like NONE: no register write.
   function automatic wb_class_t norm_class(input logic [1:0] raw);
      norm_class = (raw == WB_RSVD) ? WB_NONE : wb_class_t'(raw);
   endfunction

endpackage

// File: rtl/p5_writeback.sv
// Writeback stage: holds the execute result, waits for load data, drives the
// register-file write port, owns the architectural flags and retired count.
// Optional load timeout enabled with `define P5_LOAD_TIMEOUT_EN.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | nothing pending; a 3'b101 phase writes and counts nothing
// WAIT_MEM  | load captured, waiting for mem_valid; stalls the 3'b101 phase
// ARMED     | result held; next 3'b101 phase writes (if not NONE) and commits
module p5_writeback
   import simple_pkg::*;
#(
   parameter int DATA_W_P     = DATA_W,
   parameter int ADDR_W_P     = ADDR_W,
   parameter int LOAD_TIMEOUT = 255
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [2:0]          state,
   input  logic [1:0]          wb_class,
   input  logic [ADDR_W_P-1:0] dest,
   input  logic [DATA_W_P-1:0] alu_result,
   input  logic [3:0]          alu_flags,
   input  logic                flag_update,
   input  logic [DATA_W_P-1:0] mem_rdata,
   input  logic                mem_valid,
   output logic                op_reg_write,
   output logic [DATA_W_P-1:0] data_for_write,
   output logic [ADDR_W_P-1:0] address_for_write,
   output logic [3:0]          flags,
   output logic                stall,
   output logic [15:0]         retired,
   output logic                load_error
);

   wb_fsm_t             fsm;
   wb_class_t           class_q;
   logic [ADDR_W_P-1:0] dest_q;
   logic [DATA_W_P-1:0] data_q;
   logic [3:0]          flags_in_q;
   logic                upd_q;

`ifdef P5_LOAD_TIMEOUT_EN
   localparam logic [7:0] TMO_LAST = 8'(LOAD_TIMEOUT - 1);
   logic [7:0] tmo_cnt;
`else
   logic unused_load_timeout;
   assign unused_load_timeout = ^LOAD_TIMEOUT;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         fsm        <= WB_IDLE;
         class_q    <= WB_NONE;
         dest_q     <= '0;
         data_q     <= '0;
         flags_in_q <= '0;
         upd_q      <= 1'b0;
         flags      <= '0;
         retired    <= '0;
         load_error <= 1'b0;
`ifdef P5_LOAD_TIMEOUT_EN
         tmo_cnt    <= '0;
`endif
      end else begin
         load_error <= 1'b0;
         // A fresh capture always wins, abandoning any load still in flight.
         if (state == ST_EXEC) begin
            class_q    <= norm_class(wb_class);
            dest_q     <= dest;
            data_q     <= alu_result;
            flags_in_q <= alu_flags;
            upd_q      <= flag_update;
            fsm        <= (norm_class(wb_class) == WB_LOAD) ? WB_WAIT_MEM : WB_ARMED;
`ifdef P5_LOAD_TIMEOUT_EN
            tmo_cnt    <= '0;
`endif
         end else begin
            case (fsm)
               WB_WAIT_MEM: begin
                  if (mem_valid) begin
                     data_q <= mem_rdata;
                     fsm    <= WB_ARMED;
                  end
`ifdef P5_LOAD_TIMEOUT_EN
                  else if (tmo_cnt == TMO_LAST) begin
                     data_q     <= '0;
                     fsm        <= WB_ARMED;
                     load_error <= 1'b1;
                  end else begin
                     tmo_cnt <= tmo_cnt + 8'd1;
                  end
`endif
               end
               WB_ARMED: begin
                  if (state == ST_WB) begin
                     if (upd_q) flags <= flags_in_q;
                     retired <= retired + 16'd1;
                     fsm     <= WB_IDLE;
                  end
               end
               default: fsm <= WB_IDLE;
            endcase
         end
      end
   end

   // Held stable for the whole writeback phase so the falling-edge register
   // file sample sees settled values.
   always_comb begin
      op_reg_write      = (state == ST_WB) && (fsm == WB_ARMED) && (class_q != WB_NONE);
      stall             = (state == ST_WB) && (fsm == WB_WAIT_MEM);
      address_for_write = dest_q;
      data_for_write    = data_q;
   end

endmodule

// File: tb/tb_p5_writeback.sv
// Directed bench for p5_writeback: ALU, delayed load, NONE/reserved commits,
// capture overwrite, async reset mid-load, retired wrap, idle writeback, timeout.
module tb_p5_writeback;
   import simple_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic [2:0]  state;
   logic [1:0]  wb_class;
   logic [2:0]  dest;
   logic [15:0] alu_result;
   logic [3:0]  alu_flags;
   logic        flag_update;
   logic [15:0] mem_rdata;
   logic        mem_valid;
   logic        op_reg_write;
   logic [15:0] data_for_write;
   logic [2:0]  address_for_write;
   logic [3:0]  flags;
   logic        stall;
   logic [15:0] retired;
   logic        load_error;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clock = ~clock;

   p5_writeback #(.LOAD_TIMEOUT(4)) dut (
      .clock(clock), .reset(reset), .state(state), .wb_class(wb_class),
      .dest(dest), .alu_result(alu_result), .alu_flags(alu_flags),
      .flag_update(flag_update), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
      .op_reg_write(op_reg_write), .data_for_write(data_for_write),
      .address_for_write(address_for_write), .flags(flags), .stall(stall),
      .retired(retired), .load_error(load_error)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Advance one edge; inputs change 1ns after it, checks run 2ns after it.
   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic capture(input logic [1:0] cls, input logic [2:0] d, input logic [15:0] res,
                          input logic [3:0] fl, input logic upd);
      state = ST_EXEC; wb_class = cls; dest = d; alu_result = res;
      alu_flags = fl; flag_update = upd;
      cyc();
   endtask

   initial begin
      reset = 1'b0; state = ST_DECODE; wb_class = 2'b00; dest = '0; alu_result = '0;
      alu_flags = '0; flag_update = 1'b0; mem_rdata = '0; mem_valid = 1'b0;
      #12;
      chk("rst_we",    32'(op_reg_write), 0);
      chk("rst_stall", 32'(stall), 0);
      chk("rst_flags", 32'(flags), 0);
      chk("rst_ret",   32'(retired), 0);
      chk("rst_data",  32'(data_for_write), 0);
      chk("rst_addr",  32'(address_for_write), 0);
      chk("rst_lerr",  32'(load_error), 0);
      reset = 1'b1;
      cyc();

      // ALU write
      capture(2'b01, 3'd3, 16'h1234, 4'b0100, 1'b1);
      state = ST_WB; #1;
      chk("alu_we",    32'(op_reg_write), 1);
      chk("alu_addr",  32'(address_for_write), 3);
      chk("alu_data",  32'(data_for_write), 32'h1234);
      chk("alu_stall", 32'(stall), 0);
      cyc(); #1;
      chk("alu_flags", 32'(flags), 32'h4);
      chk("alu_ret",   32'(retired), 1);
      chk("alu_we_off", 32'(op_reg_write), 0);

      // Load with mem_valid in the third writeback cycle
      capture(2'b10, 3'd5, 16'h7777, 4'b1111, 1'b0);
      state = ST_WB; #1;
      chk("ld_stall1", 32'(stall), 1);
      chk("ld_we1",    32'(op_reg_write), 0);
      cyc(); #1;
      chk("ld_stall2", 32'(stall), 1);
      cyc();
      mem_valid = 1'b1; mem_rdata = 16'hBEEF; #1;
      chk("ld_stall3", 32'(stall), 1);
      cyc();
      mem_valid = 1'b0; mem_rdata = 16'h0000; #1;
      chk("ld_stall4", 32'(stall), 0);
      chk("ld_we4",    32'(op_reg_write), 1);
      chk("ld_addr",   32'(address_for_write), 5);
      chk("ld_data",   32'(data_for_write), 32'hBEEF);
      cyc(); #1;
      chk("ld_ret",    32'(retired), 2);
      chk("ld_flags",  32'(flags), 32'h4);

      // mem_valid while idle is ignored
      mem_valid = 1'b1; mem_rdata = 16'hDEAD;
      cyc();
      mem_valid = 1'b0; #1;
      chk("idle_mv_we",   32'(op_reg_write), 0);
      chk("idle_mv_data", 32'(data_for_write), 32'hBEEF);
      chk("idle_mv_ret",  32'(retired), 2);

      // NONE with flag update (compare)
      capture(2'b00, 3'd6, 16'h5555, 4'b1001, 1'b1);
      state = ST_WB; #1;
      chk("none_we",    32'(op_reg_write), 0);
      chk("none_stall", 32'(stall), 0);
      cyc(); #1;
      chk("none_flags", 32'(flags), 32'h9);
      chk("none_ret",   32'(retired), 3);

      // Reserved class behaves as NONE; no flag update
      capture(2'b11, 3'd4, 16'h1111, 4'b0110, 1'b0);
      state = ST_WB; #1;
      chk("rsv_we", 32'(op_reg_write), 0);
      cyc(); #1;
      chk("rsv_ret",   32'(retired), 4);
      chk("rsv_flags", 32'(flags), 32'h9);

      // New capture abandons a pending load
      capture(2'b10, 3'd1, 16'h0000, 4'b0000, 1'b0);
      capture(2'b01, 3'd2, 16'h00A5, 4'b0010, 1'b0);
      state = ST_WB; #1;
      chk("ovr_stall", 32'(stall), 0);
      chk("ovr_we",    32'(op_reg_write), 1);
      chk("ovr_data",  32'(data_for_write), 32'h00A5);
      chk("ovr_addr",  32'(address_for_write), 2);
      cyc(); #1;
      chk("ovr_ret",   32'(retired), 5);
      chk("ovr_flags", 32'(flags), 32'h9);

      // Default build: WAIT_MEM persists; with timeout it resolves to a zero write
      capture(2'b10, 3'd7, 16'hFFFF, 4'b0000, 1'b0);
      state = ST_WB;
`ifdef P5_LOAD_TIMEOUT_EN
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("tmo_stall", 32'(stall), 1);
         chk("tmo_lerr0", 32'(load_error), 0);
         cyc();
      end
      #1;
      chk("tmo_lerr",  32'(load_error), 1);
      chk("tmo_stall_off", 32'(stall), 0);
      chk("tmo_we",    32'(op_reg_write), 1);
      chk("tmo_data",  32'(data_for_write), 0);
      chk("tmo_addr",  32'(address_for_write), 7);
      cyc(); #1;
      chk("tmo_lerr_off", 32'(load_error), 0);
      chk("tmo_ret",   32'(retired), 6);
`else
      for (int i = 0; i < 12; i++) cyc();
      #1;
      chk("nto_stall", 32'(stall), 1);
      chk("nto_lerr",  32'(load_error), 0);
      chk("nto_ret",   32'(retired), 5);
`endif

      // Async reset during a pending load
      capture(2'b10, 3'd1, 16'h2222, 4'b0000, 1'b0);
      state = ST_WB; #1;
      chk("arst_pre_stall", 32'(stall), 1);
      #1; reset = 1'b0; #1;
      chk("arst_stall", 32'(stall), 0);
      chk("arst_we",    32'(op_reg_write), 0);
      chk("arst_flags", 32'(flags), 0);
      chk("arst_ret",   32'(retired), 0);
      state = ST_DECODE;
      @(negedge clock); reset = 1'b1;
      cyc();

      // Retired wraps from FFFF to 0
      force dut.retired = 16'hFFFF;
      #1;
      release dut.retired;
      capture(2'b01, 3'd0, 16'h0042, 4'b0001, 1'b0);
      state = ST_WB;
      cyc(); #1;
      chk("wrap_ret", 32'(retired), 0);

      // Writeback phase with nothing captured
      cyc(); #1;
      chk("idle_we",  32'(op_reg_write), 0);
      chk("idle_ret", 32'(retired), 0);
      chk("idle_flags", 32'(flags), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
